// File: rtl/module_scan_tecladohex_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : module_scan_tecladohex_if
// Description : Bundle of keypad-side and decoder-side signals of the 4x4 hex
//               keypad scan controller.
//                 fila_in   - raw keypad row lines (asynchronous, active-high)
//                 col_out   - one-hot column drive
//                 fila/col  - debounced one-hot row/column of the held key
//                 tecla     - debounced "key held" level
//                 key_valid - one-cycle pulse per accepted press
//               master : the scan controller (drives columns and results)
//               slave  : keypad model / decoder side
// Revision    : 1.0 - initial release
// ============================================================================
interface module_scan_tecladohex_if;
    logic [3:0] fila_in;
    logic [3:0] col_out;
    logic [3:0] fila;
    logic [3:0] col;
    logic       tecla;
    logic       key_valid;

    modport master (
        input  fila_in,
        output col_out,
        output fila,
        output col,
        output tecla,
        output key_valid
    );

    modport slave (
        output fila_in,
        input  col_out,
        input  fila,
        input  col,
        input  tecla,
        input  key_valid
    );
endinterface
`default_nettype wire

// File: rtl/module_scan_tecladohex.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : module_scan_tecladohex
// Description : Scan controller for a 4x4 hex keypad. Drives the columns
//               one-hot, synchronizes the row lines, and debounces both press
//               and release. Presents a stable one-hot fila/col pair, a tecla
//               level and a one-cycle key_valid pulse per accepted press.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous active-high reset
//               kbd  - module_scan_tecladohex_if.master
//                      (fila_in in; col_out, fila, col, tecla, key_valid out)
// Parameters  : SCAN_DIV     - clock cycles per column dwell (>= 4)
//               DEBOUNCE_CNT - consecutive matching ticks to accept a press
//                              or a release (>= 1)
// Revision    : 1.0 - initial release
// ============================================================================
module module_scan_tecladohex #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input  wire logic               clk,
    input  wire logic               rst,
    module_scan_tecladohex_if.master kbd
);

    localparam int                  c_DIV_W    = $clog2(SCAN_DIV);
    localparam int                  c_CNT_W    = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0]  c_DB_TERM  = c_CNT_W'(DEBOUNCE_CNT);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Row synchronizer: fila_in is asynchronous to clk.
    // ------------------------------------------------------------------
    logic [3:0] r_sync;
    logic [3:0] r_rows;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 4'b0000;
            r_rows <= 4'b0000;
        end else begin
            r_sync <= kbd.fila_in;
            r_rows <= r_sync;
        end
    end

    // ------------------------------------------------------------------
    // Column dwell divider. The tick lands on the last cycle of the dwell,
    // so the two synchronizer stages have settled on the new column.
    // ------------------------------------------------------------------
    logic [c_DIV_W-1:0] r_div;
    logic               w_tick;

    assign w_tick = (r_div == c_DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Scan / debounce state machine
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [3:0]         r_col_out;
    logic [3:0]         r_cap_f;
    logic [3:0]         r_cap_c;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_fila;
    logic [3:0]         r_col;
    logic               r_tecla;
    logic               r_key_valid;

    state_t             w_state_nxt;
    logic [3:0]         w_col_out_nxt;
    logic [3:0]         w_cap_f_nxt;
    logic [3:0]         w_cap_c_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [3:0]         w_fila_nxt;
    logic [3:0]         w_col_nxt;
    logic               w_tecla_nxt;
    logic               w_key_valid_nxt;

    logic               w_rows_onehot;
    logic               w_rows_match;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic [3:0]         w_col_rot;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
    // This rejects ghosting / multi-key patterns before capture.
    assign w_rows_onehot = (r_rows != 4'b0000) &&
                           ((r_rows & (r_rows - 4'd1)) == 4'b0000);
    assign w_rows_match  = (r_rows == r_cap_f);
    assign w_cnt_inc     = r_cnt + c_CNT_ONE;
    assign w_col_rot     = {r_col_out[2:0], r_col_out[3]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_SCAN;
            r_col_out   <= 4'b0001;
            r_cap_f     <= 4'b0000;
            r_cap_c     <= 4'b0000;
            r_cnt       <= '0;
            r_fila      <= 4'b0000;
            r_col       <= 4'b0000;
            r_tecla     <= 1'b0;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_col_out   <= w_col_out_nxt;
            r_cap_f     <= w_cap_f_nxt;
            r_cap_c     <= w_cap_c_nxt;
            r_cnt       <= w_cnt_nxt;
            r_fila      <= w_fila_nxt;
            r_col       <= w_col_nxt;
            r_tecla     <= w_tecla_nxt;
            r_key_valid <= w_key_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_col_out_nxt   = r_col_out;
        w_cap_f_nxt     = r_cap_f;
        w_cap_c_nxt     = r_cap_c;
        w_cnt_nxt       = r_cnt;
        w_fila_nxt      = r_fila;
        w_col_nxt       = r_col;
        w_tecla_nxt     = r_tecla;
        w_key_valid_nxt = 1'b0;

        if (w_tick) begin
            unique case (r_state)
                ST_SCAN: begin
                    if (w_rows_onehot) begin
                        // Freeze the column on the candidate key.
                        w_cap_f_nxt = r_rows;
                        w_cap_c_nxt = r_col_out;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_DEBOUNCE;
                    end else begin
                        w_col_out_nxt = w_col_rot;
                    end
                end

                ST_DEBOUNCE: begin
                    if (w_rows_match) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_DB_TERM) begin
                            w_state_nxt     = ST_HOLD;
                            w_tecla_nxt     = 1'b1;
                            w_fila_nxt      = r_cap_f;
                            w_col_nxt       = r_cap_c;
                            w_key_valid_nxt = 1'b1;
                        end
                    end else begin
                        // Bounce: abandon the candidate and keep scanning.
                        w_state_nxt   = ST_SCAN;
                        w_col_out_nxt = w_col_rot;
                    end
                end

                ST_HOLD: begin
                    if (!w_rows_match) begin
                        if (DEBOUNCE_CNT == 1) begin
                            // A single mismatch tick already completes release.
                            w_state_nxt   = ST_SCAN;
                            w_tecla_nxt   = 1'b0;
                            w_fila_nxt    = 4'b0000;
                            w_col_nxt     = 4'b0000;
                            w_cnt_nxt     = '0;
                            w_col_out_nxt = w_col_rot;
                        end else begin
                            // This tick is the first mismatch already.
                            w_cnt_nxt   = c_CNT_ONE;
                            w_state_nxt = ST_RELEASE;
                        end
                    end
                end

                ST_RELEASE: begin
                    if (!w_rows_match) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_DB_TERM) begin
                            w_state_nxt   = ST_SCAN;
                            w_tecla_nxt   = 1'b0;
                            w_fila_nxt    = 4'b0000;
                            w_col_nxt     = 4'b0000;
                            w_cnt_nxt     = '0;
                            w_col_out_nxt = w_col_rot;
                        end
                    end else begin
                        // Re-contact: key still held, no new press reported.
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_HOLD;
                    end
                end

                default: begin
                    w_state_nxt = ST_SCAN;
                end
            endcase
        end
    end

    assign kbd.col_out   = r_col_out;
    assign kbd.fila      = r_fila;
    assign kbd.col       = r_col;
    assign kbd.tecla     = r_tecla;
    assign kbd.key_valid = r_key_valid;

endmodule
`default_nettype wire

// File: tb/tb_module_scan_tecladohex.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_module_scan_tecladohex
// Description : Self-checking bench for module_scan_tecladohex. A keypad
//               model feeds row lines from a pressed-key matrix, and a
//               behavioural reference (tick counting, match/miss run lengths)
//               predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_module_scan_tecladohex;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    module_scan_tecladohex_if kbd ();

    module_scan_tecladohex #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kbd (kbd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Pressed-key matrix, bit index = row*4 + column.
    logic [15:0] pressed = 16'h0000;

    function automatic logic [15:0] key(input int r, input int c);
        logic [15:0] k;
        k = 16'h0001 << (r * 4 + c);
        return k;
    endfunction

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int         m_div, m_col, m_ccol, m_good, m_miss, m_presses;
    logic [3:0] m_s1, m_s2, m_row, m_r;
    bit         m_cand, m_held, m_kv, m_tick;

    initial m_presses = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_div  = 0; m_col = 0; m_ccol = 0; m_good = 0; m_miss = 0;
            m_s1   = 4'b0; m_s2 = 4'b0; m_row = 4'b0;
            m_cand = 1'b0; m_held = 1'b0; m_kv = 1'b0; m_tick = 1'b0;
        end else begin
            m_r    = m_s2;
            m_tick = (m_div == SCAN_DIV - 1);
            m_kv   = 1'b0;
            m_s2   = m_s1;
            m_s1   = kbd.fila_in;
            m_div  = (m_div + 1) % SCAN_DIV;
            if (m_tick) begin
                if (m_held) begin
                    if (m_r != m_row) begin
                        m_miss++;
                        if (m_miss >= DEBOUNCE_CNT) begin
                            m_held = 1'b0;
                            m_col  = (m_col + 1) % 4;
                        end
                    end else begin
                        m_miss = 0;
                    end
                end else if (m_cand) begin
                    if (m_r == m_row) begin
                        m_good++;
                        if (m_good == DEBOUNCE_CNT) begin
                            m_cand = 1'b0;
                            m_held = 1'b1;
                            m_miss = 0;
                            m_kv   = 1'b1;
                            m_presses++;
                        end
                    end else begin
                        m_cand = 1'b0;
                        m_col  = (m_col + 1) % 4;
                    end
                end else if ($countones(m_r) == 1) begin
                    m_cand = 1'b1;
                    m_row  = m_r;
                    m_ccol = m_col;
                    m_good = 0;
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end
        end
    end

    // Keypad: a row line is high when a pressed key sits on the driven column.
    initial begin
        kbd.fila_in = 4'b0000;
        forever begin
            logic [3:0] f;
            @(negedge clk);
            for (int r = 0; r < 4; r++) f[r] = pressed[r * 4 + m_col];
            kbd.fila_in = f;
        end
    end

    // Per-cycle comparison against the model.
    int dut_presses = 0;
    initial begin
        forever begin
            logic [3:0] e_colout, e_fila, e_col;
            @(negedge clk);
            if (!rst) begin
                e_colout = 4'b0001 << m_col;
                e_fila   = m_held ? m_row : 4'b0000;
                e_col    = m_held ? (4'b0001 << m_ccol) : 4'b0000;
                check("col_out",   32'(kbd.col_out),   32'(e_colout));
                check("fila",      32'(kbd.fila),      32'(e_fila));
                check("col",       32'(kbd.col),       32'(e_col));
                check("tecla",     32'(kbd.tecla),     32'(m_held));
                check("key_valid", 32'(kbd.key_valid), 32'(m_kv));
                if (kbd.key_valid === 1'b1) dut_presses++;
            end
        end
    end

    // Returns just after the n-th tick edge from now.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 2 * SCAN_DIV && !seen; k++) begin
                @(posedge clk);
                #1;
                seen = m_tick;
            end
            if (!seen) check("tick_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic wait_held(input string tag);
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (m_held) return;
        end
        check(tag, 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col_out"},   32'(kbd.col_out),   32'h1);
        check({tag, "_fila"},      32'(kbd.fila),      32'h0);
        check({tag, "_col"},       32'(kbd.col),       32'h0);
        check({tag, "_tecla"},     32'(kbd.tecla),     32'h0);
        check({tag, "_key_valid"}, 32'(kbd.key_valid), 32'h0);
    endtask

    initial begin
        int rise;
        int base;

        // Reset state, then free rotation with no key.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Key '1' held through reset: capture at cycle 3, accept at cycle 15.
        pressed = key(0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        rise = -1;
        for (int c = 0; c < 40 && rise < 0; c++) begin
            @(posedge clk);
            #1;
            if (kbd.tecla === 1'b1) begin
                rise = c;
                check("press1_kv", 32'(kbd.key_valid), 32'd1);
            end
        end
        check("press1_latency", 32'(rise), 32'd15);
        pressed = 16'h0;
        wait_ticks(6);

        // Key '5' (row1, col1): column stays frozen while held.
        pressed = key(1, 1);
        wait_held("press5_timeout");
        check("press5_fila", 32'(kbd.fila), 32'h2);
        check("press5_col",  32'(kbd.col),  32'h2);
        wait_ticks(5);
        check("press5_frozen", 32'(kbd.col_out), 32'h2);
        pressed = 16'h0;
        wait_ticks(6);

        // Bounce on key '9' (row2, col2): present for two ticks only.
        pressed = key(2, 2);
        for (int k = 0; k < 200 && !m_cand; k++) begin
            @(posedge clk);
            #1;
        end
        check("bounce_capture", 32'(m_cand), 32'd1);
        wait_ticks(1);
        pressed = 16'h0;
        wait_ticks(1);
        check("bounce_tecla",   32'(kbd.tecla),   32'd0);
        check("bounce_col_out", 32'(kbd.col_out), 32'h8);
        wait_ticks(4);

        // Release chatter on key 'D' (row3, col3).
        base    = dut_presses;
        pressed = key(3, 3);
        wait_held("pressD_timeout");
        pressed = 16'h0;
        wait_ticks(2);
        pressed = key(3, 3);
        wait_ticks(1);
        check("chatter_hold", 32'(kbd.tecla), 32'd1);
        pressed = 16'h0;
        wait_ticks(2);
        check("release_pending", 32'(kbd.tecla), 32'd1);
        wait_ticks(1);
        check("release_tecla", 32'(kbd.tecla), 32'd0);
        check("release_fila",  32'(kbd.fila),  32'h0);
        @(negedge clk);
        check("chatter_pulses", 32'(dut_presses - base), 32'd1);

        // Ghost pattern 0011 on column 0100 is never captured.
        pressed = key(0, 2) | key(1, 2);
        wait_ticks(12);
        check("ghost_tecla", 32'(kbd.tecla), 32'd0);
        pressed = 16'h0;
        wait_ticks(2);

        // Asynchronous reset during HOLD on key 'B' (row1, col3).
        pressed = key(1, 3);
        wait_held("pressB_timeout");
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        pressed = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_ticks(2);

        // Randomized key activity: idle, single keys, multi-key, short bursts.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       pressed = 16'h0;
                1, 2:    pressed = key($urandom_range(0, 3), $urandom_range(0, 3));
                default: pressed = key($urandom_range(0, 3), $urandom_range(0, 3)) |
                                   key($urandom_range(0, 3), $urandom_range(0, 3));
            endcase
            wait_ticks($urandom_range(1, 12));
        end
        pressed = 16'h0;
        wait_ticks(8);
        @(negedge clk);
        check("press_count", 32'(dut_presses), 32'(m_presses));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/module_scan_tecladohex.md
# module_scan_tecladohex

Scan controller for the 4x4 hex keypad. It drives the keypad columns one-hot, synchronizes and samples the row lines, and debounces both press and release. It presents a stable one-hot `fila`/`col` pair plus a `tecla` level to the keypad decoder (fila/col/tecla to num/rdy), along with a one-cycle `key_valid` pulse per accepted press for downstream capture logic.

## Interface
- `SCAN_DIV`, default 4: clock cycles per column dwell. Must be ≥ 4.
- `DEBOUNCE_CNT`, default 3: number of consecutive matching ticks required to accept a press or a release. Must be ≥ 1.
- `clk`  in  1  single system clock. All logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fila_in`  in  4  raw keypad row lines, active-high, asynchronous to `clk`.
- `col_out`  out  4  column drive, one-hot, active-high.
- `fila`  out  4  debounced row of the held key, one-hot; 0 when no key is held.
- `col`  out  4  debounced column of the held key, one-hot; 0 when no key is held.
- `tecla`  out  1  high while a debounced key is held.
- `key_valid`  out  1  one-cycle pulse when a press is accepted.

## Operation
- `fila_in` passes through a 2-flop synchronizer. Call the synchronized value `rows`.
- Divider `div` counts 0..SCAN_DIV-1 and wraps. A `tick` occurs when div == SCAN_DIV-1. Rows are only evaluated on a tick.
- Debounce counter `cnt` is $clog2(DEBOUNCE_CNT+1) bits wide.
- Captured registers `cap_f` and `cap_c` are 4 bits each.
- SCAN:
  - On each tick with rows == 0 or rows not one-hot, `col_out` rotates left (0001→0010→0100→1000→0001).
  - On a tick with rows one-hot: cap_f ← rows, cap_c ← col_out, cnt ← 0, go to DEBOUNCE. `col_out` is not rotated.
- DEBOUNCE (`col_out` frozen):
  - On a tick with rows == cap_f: cnt+1. When cnt+1 == DEBOUNCE_CNT, go to HOLD, set `tecla`=1, `fila`=cap_f, `col`=cap_c, and pulse `key_valid`.
  - On a tick with any other rows: go to SCAN and rotate `col_out`.
- HOLD (`col_out` frozen):
  - On a tick with rows == cap_f: stay.
  - On a tick with rows != cap_f: cnt ← 1 (or go directly to SCAN if DEBOUNCE_CNT == 1, with release actions as below), go to RELEASE.
- RELEASE:
  - On a tick with rows != cap_f: cnt+1. When cnt reaches DEBOUNCE_CNT: `tecla`, `fila`, `col` ← 0, rotate `col_out`, go to SCAN.
  - On a tick with rows == cap_f: cnt ← 0, return to HOLD. `tecla` stays high and no new `key_valid` is issued.
- Ghosting and multi-key: a non-one-hot row pattern is never captured. A second key pressed during HOLD counts as a mismatch (rows != cap_f).
- `key_valid` fires exactly once per accepted press, never on release or on a return from RELEASE to HOLD.

## Timing
- Reset values: `col_out`=0001, `fila`=0000, `col`=0000, `tecla`=0, `key_valid`=0, state SCAN, div=0, cnt=0, synchronizer=0.
- Reset asserted mid-operation takes effect immediately (asynchronous): outputs return to their reset values with no `key_valid`. After deassertion, scanning restarts at column 0.
- All outputs are registered. `tecla`, `fila`, `col`, and `key_valid` change on the same edge.
- Input-to-`rows` latency is 2 cycles. `col_out` holds each column for SCAN_DIV cycles, which leaves ≥ 2 cycles of settle time before the sampling tick.
- Full scan period is 4·SCAN_DIV cycles.
- Press latency, measured from the capturing tick: DEBOUNCE_CNT further ticks, i.e. DEBOUNCE_CNT·SCAN_DIV cycles.
- Release latency: DEBOUNCE_CNT ticks of mismatch.
- Cycle 0 is the first rising edge after `rst` deasserts. With defaults, ticks fall at cycles 3, 7, 11, 15, …

## Test plan
- Reset/rotation: no key pressed → `col_out` cycles 0001, 0010, 0100, 1000, each held 4 cycles, repeating every 16 cycles; `tecla`=0 and `key_valid`=0 throughout.
- Press '5': keypad model returns fila_in=0010 whenever col_out==0010 → `tecla` rises with `fila`=0010, `col`=0010, a single `key_valid` pulse, and `col_out` frozen at 0010 until release.
- Press '1' held from reset (row0/col0) → capture at the cycle-3 tick; `tecla`=1 and `key_valid`=1 after the cycle-15 tick edge (3 further ticks).
- Bounce: key '9' present for 2 ticks then absent → `tecla` stays 0, no `key_valid`, scanning resumes at 1000.
- Release chatter: key 'D' held; release with one tick of re-contact after 2 mismatch ticks → returns to HOLD, no second pulse; a clean release then drops `tecla`/`fila`/`col` to 0 after 3 ticks.
- Ghost and reset: fila_in=0011 on col 0100 → ignored, rotation continues. `rst` asserted during HOLD → all outputs reset at once; `col_out`=0001.
